vga_cell_scanner: RTL and testbench
===================================

// Module: vga_cell_scanner
// PURPOSE
//  Raster scanner on the pe_array VGA read port: generates 640x480 VGA timing, maps each pixel to a
//  cell address (adr_x_vga/adr_y_vga), samples the returned cell state and emits sync + RGB aligned
//  to it. Also flags vertical blanking so the generation controller steps the array between frames.
// PARAMETERS
//  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, pixel steps
//  V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing, lines
//  CELL_SHIFT 4         : log2 pixels per cell edge (16x16 px cells)
//  RD_LAT     1         : pix_en steps from adr_*_vga change to valid vga_state (>=1)
//  ALIVE_RGB 12'hFFF, DEAD_RGB 12'h000, GRID_RGB 12'h444, BG_RGB 12'h00F : colours
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 async active-high reset
//  pix_en       in   1                 pixel-rate enable; all state advances only when high
//  grid_en      in   1                 draw cell grid lines
//  adr_x_vga    out  `N_PX_BITS        cell column to pe_array
//  adr_y_vga    out  `N_PY_BITS        cell row to pe_array
//  vga_state    in   `PE_STATE_BITS    pe_array vga_out
//  hsync        out  1                 active-low horizontal sync
//  vsync        out  1                 active-low vertical sync
//  de           out  1                 data enable (active video)
//  rgb          out  12                4:4:4 colour, 0 when de=0
//  vblank       out  1                 high while vcnt >= V_ACTIVE (counter domain, unpipelined)
//  frame_start  out  1                 one clk pulse on the pix_en step where vcnt becomes V_ACTIVE, hcnt=0
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): hcnt=vcnt=0, adr_*=0, hsync=vsync=1, de=0, rgb=0,
//    vblank=0, frame_start=0, pipeline cleared. First pix_en after release processes hcnt=0,vcnt=0.
//  - Counters: hcnt 0..H_TOTAL-1 (800), wraps to 0 and vcnt++; vcnt 0..V_TOTAL-1 (525), wraps to 0.
//    Both hold when pix_en=0. Widths: 10 bits each.
//  - Raw sync: hsync_n low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751);
//    vsync_n low for 490 <= vcnt < 492. de_raw = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
//  - in_grid = de_raw && (hcnt>>CELL_SHIFT) < `N_PX && (vcnt>>CELL_SHIFT) < `N_PY.
//  - Stage A (pix_en step k): adr_x_vga <= in_grid ? hcnt>>CELL_SHIFT : 0; adr_y_vga likewise; register
//    de_raw, syncs, in_grid, grid_line = (hcnt[CELL_SHIFT-1:0]==0)||(vcnt[CELL_SHIFT-1:0]==0).
//  - Delay line of RD_LAT-1 further pix_en steps carries these flags; vga_state sampled on step k+RD_LAT.
//  - Output stage (step k+RD_LAT): hsync/vsync/de registered from delayed flags; rgb =
//    !de ? 0 : !in_grid ? BG_RGB : (grid_en && grid_line) ? GRID_RGB : vga_state[0] ? ALIVE_RGB : DEAD_RGB.
//  - Total latency counters->outputs: RD_LAT+1 pix_en steps; sync, de, rgb stay mutually aligned.
//  - vblank and frame_start come straight from counters (early, unpipelined); frame_start lasts one clk
//    even if pix_en is held high continuously; never asserted during reset.
//  - Cells outside the visible area are never addressed; grid smaller than screen is padded with BG_RGB.
//  - Every registered output is driven; no combinational path from vga_state to any output.
// STRUCTURE
//  - Package vga_pkg: timing constants, H_TOTAL/V_TOTAL, rgb12_t typedef, colour constants.
//  - Sub-module vga_timing (counters, raw sync/de, vblank, frame_start); vga_cell_scanner adds address
//    mapping, RD_LAT delay line and colour mux. Array sizes from pe_array_decs.sv macros.
// TESTING (640x480, CELL_SHIFT=4, `N_PX=`N_PY=16, RD_LAT=1, pix_en every 4th clk)
//  1 Free run 2 frames -> hsync low 96 steps from hcnt 656, period 800; vsync low lines 490-491,
//    period 525 lines; de high exactly 640x480 steps per frame.
//  2 Pixel hcnt=35,vcnt=20 -> adr_x_vga=2, adr_y_vga=1; rgb for it appears 2 pix_en steps later.
//  3 Model cell (2,1) alive only, grid_en=0 -> rgb=FFF for pixels x32..47,y16..31, 000 elsewhere
//    in 256x256 grid, 00F for x>=256 or y>=256, 0 during blanking.
//  4 grid_en=1 -> pixels with x%16==0 or y%16==0 inside grid show 444, overriding alive.
//  5 Assert rst at hcnt=300,vcnt=100 for 3 clks -> outputs go to reset values immediately; after release
//    hsync first falls 656+2 steps later; frame_start pulses once per frame, 1 clk wide.
//  6 pix_en held low 50 clks mid-line -> counters, adr, outputs frozen; resume without glitches.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA scanner types and defaults: 640x480 timing, colours, pixel flag bundle.
// Array geometry macros fall back to a 16x16 pe_array when the array headers are absent.
`ifndef N_PX
`define N_PX 16
`endif
`ifndef N_PY
`define N_PY 16
`endif
`ifndef N_PX_BITS
`define N_PX_BITS 4
`endif
`ifndef N_PY_BITS
`define N_PY_BITS 4
`endif
`ifndef PE_STATE_BITS
`define PE_STATE_BITS 2
`endif

package vga_pkg;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_CELL_SHIFT = 4;
  localparam int unsigned VGA_RD_LAT     = 1;
  localparam int unsigned CNT_W          = 10;

  localparam int unsigned N_PX          = `N_PX;
  localparam int unsigned N_PY          = `N_PY;
  localparam int unsigned N_PX_BITS     = `N_PX_BITS;
  localparam int unsigned N_PY_BITS     = `N_PY_BITS;
  localparam int unsigned PE_STATE_BITS = `PE_STATE_BITS;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t ALIVE_RGB = 12'hFFF;
  localparam rgb12_t DEAD_RGB  = 12'h000;
  localparam rgb12_t GRID_RGB  = 12'h444;
  localparam rgb12_t BG_RGB    = 12'h00F;

  // Per-pixel attributes carried alongside the pe_array read
  typedef struct packed {
    logic de;
    logic hsync_n;
    logic vsync_n;
    logic in_grid;
    logic grid_line;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                        in_grid: 1'b0, grid_line: 1'b0};
endpackage

// File: rtl/vga_timing.sv
// Raster counters with raw sync/de decode, plus early vblank and frame_start for the
// generation controller.
module vga_timing #(
  parameter int unsigned H_ACTIVE = vga_pkg::VGA_H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::VGA_H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::VGA_H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::VGA_H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::VGA_V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::VGA_V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::VGA_V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::VGA_V_BP
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pix_en,
  output logic [vga_pkg::CNT_W-1:0]  o_hcnt,
  output logic [vga_pkg::CNT_W-1:0]  o_vcnt,
  output logic                       o_hsync_n_c,
  output logic                       o_vsync_n_c,
  output logic                       o_de_c,
  output logic                       o_vblank,
  output logic                       o_frame_start
);
  import vga_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic [CNT_W-1:0] w_hcnt_nx, w_vcnt_nx;
  logic             w_h_last, w_v_last;
  logic             r_vblank, r_frame_start;

  always_comb begin
    w_h_last  = (r_hcnt == CNT_W'(H_TOT - 1));
    w_v_last  = (r_vcnt == CNT_W'(V_TOT - 1));
    w_hcnt_nx = w_h_last ? '0 : r_hcnt + CNT_W'(1);
    w_vcnt_nx = r_vcnt;
    if (w_h_last) begin
      w_vcnt_nx = w_v_last ? '0 : r_vcnt + CNT_W'(1);
    end
  end

  // frame_start is cleared every clk so a held-high pix_en still gives a single-clk pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (i_pix_en) begin
        r_hcnt        <= w_hcnt_nx;
        r_vcnt        <= w_vcnt_nx;
        r_vblank      <= (w_vcnt_nx >= CNT_W'(V_ACTIVE));
        r_frame_start <= w_h_last && (r_vcnt == CNT_W'(V_ACTIVE - 1));
      end
    end
  end

  always_comb begin
    o_hsync_n_c = !((r_hcnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                    (r_hcnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    o_vsync_n_c = !((r_vcnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                    (r_vcnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    o_de_c      = (r_hcnt < CNT_W'(H_ACTIVE)) && (r_vcnt < CNT_W'(V_ACTIVE));
  end

  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_vblank      = r_vblank;
  assign o_frame_start = r_frame_start;
endmodule

// File: rtl/vga_cell_scanner.sv
// Scans the pe_array VGA read port: pixel -> cell address, waits out the read latency,
// then emits sync/de/rgb aligned with the returned cell state.
module vga_cell_scanner #(
  parameter int unsigned H_ACTIVE   = vga_pkg::VGA_H_ACTIVE,
  parameter int unsigned H_FP       = vga_pkg::VGA_H_FP,
  parameter int unsigned H_SYNC     = vga_pkg::VGA_H_SYNC,
  parameter int unsigned H_BP       = vga_pkg::VGA_H_BP,
  parameter int unsigned V_ACTIVE   = vga_pkg::VGA_V_ACTIVE,
  parameter int unsigned V_FP       = vga_pkg::VGA_V_FP,
  parameter int unsigned V_SYNC     = vga_pkg::VGA_V_SYNC,
  parameter int unsigned V_BP       = vga_pkg::VGA_V_BP,
  parameter int unsigned CELL_SHIFT = vga_pkg::VGA_CELL_SHIFT,
  parameter int unsigned RD_LAT     = vga_pkg::VGA_RD_LAT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pix_en,
  input  logic                                grid_en,
  output logic [vga_pkg::N_PX_BITS-1:0]       adr_x_vga,
  output logic [vga_pkg::N_PY_BITS-1:0]       adr_y_vga,
  input  logic [vga_pkg::PE_STATE_BITS-1:0]   vga_state,
  output logic                                hsync,
  output logic                                vsync,
  output logic                                de,
  output logic [11:0]                         rgb,
  output logic                                vblank,
  output logic                                frame_start
);
  import vga_pkg::*;

  logic [CNT_W-1:0]     w_hcnt, w_vcnt, w_cx, w_cy;
  logic                 w_hs_n, w_vs_n, w_de_raw, w_in_grid;
  pix_flags_t           w_flags_a, w_out;
  pix_flags_t           r_dly [RD_LAT];
  logic [N_PX_BITS-1:0] r_adr_x;
  logic [N_PY_BITS-1:0] r_adr_y;
  logic                 r_hsync, r_vsync, r_de;
  rgb12_t               r_rgb, w_rgb_nx;
  logic                 w_unused_state;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pix_en      (pix_en),
    .o_hcnt        (w_hcnt),
    .o_vcnt        (w_vcnt),
    .o_hsync_n_c   (w_hs_n),
    .o_vsync_n_c   (w_vs_n),
    .o_de_c        (w_de_raw),
    .o_vblank      (vblank),
    .o_frame_start (frame_start)
  );

  always_comb begin
    w_cx      = w_hcnt >> CELL_SHIFT;
    w_cy      = w_vcnt >> CELL_SHIFT;
    w_in_grid = w_de_raw && (w_cx < CNT_W'(N_PX)) && (w_cy < CNT_W'(N_PY));
    w_flags_a = '{de:        w_de_raw,
                  hsync_n:   w_hs_n,
                  vsync_n:   w_vs_n,
                  in_grid:   w_in_grid,
                  grid_line: (w_hcnt[CELL_SHIFT-1:0] == '0) || (w_vcnt[CELL_SHIFT-1:0] == '0)};
  end

  // Stage A plus the flag delay line covering the pe_array read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adr_x <= '0;
      r_adr_y <= '0;
      for (int i = 0; i < RD_LAT; i++) r_dly[i] <= FLAGS_IDLE;
    end else if (pix_en) begin
      r_adr_x  <= w_in_grid ? w_cx[N_PX_BITS-1:0] : '0;
      r_adr_y  <= w_in_grid ? w_cy[N_PY_BITS-1:0] : '0;
      r_dly[0] <= w_flags_a;
      for (int i = 1; i < RD_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  always_comb begin
    w_out    = r_dly[RD_LAT-1];
    w_rgb_nx = DEAD_RGB;
    if (!w_out.de)                        w_rgb_nx = '0;
    else if (!w_out.in_grid)              w_rgb_nx = BG_RGB;
    else if (grid_en && w_out.grid_line)  w_rgb_nx = GRID_RGB;
    else if (vga_state[0])                w_rgb_nx = ALIVE_RGB;
    else                                  w_rgb_nx = DEAD_RGB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else if (pix_en) begin
      r_hsync <= w_out.hsync_n;
      r_vsync <= w_out.vsync_n;
      r_de    <= w_out.de;
      r_rgb   <= w_rgb_nx;
    end
  end

  // Only bit 0 of the cell state selects the colour
  assign w_unused_state = ^vga_state;

  assign adr_x_vga = r_adr_x;
  assign adr_y_vga = r_adr_y;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign de        = r_de;
  assign rgb       = r_rgb;
endmodule

// File: tb/tb_vga_cell_scanner.sv
// Scoreboard bench for vga_cell_scanner on a scaled-down raster: a pixel-level reference
// model queues expected outputs per pix_en step; a monitor pops and compares.
module tb_vga_cell_scanner;
  localparam int T_HA = 48, T_HFP = 4, T_HS = 8, T_HBP = 4;
  localparam int T_VA = 40, T_VFP = 2, T_VS = 2, T_VBP = 4;
  localparam int T_HT = T_HA + T_HFP + T_HS + T_HBP;
  localparam int T_VT = T_VA + T_VFP + T_VS + T_VBP;
  localparam int T_CS = 1;
  localparam int T_RDL = 1;
  localparam int CPX = 2 ** T_CS;
  localparam int FRAME = T_HT * T_VT;
  localparam int NPX = vga_pkg::N_PX;
  localparam int NPY = vga_pkg::N_PY;
  localparam int NXB = vga_pkg::N_PX_BITS;
  localparam int NYB = vga_pkg::N_PY_BITS;
  localparam int SB  = vga_pkg::PE_STATE_BITS;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
  } out_t;

  typedef struct packed {
    logic [NXB-1:0] ax;
    logic [NYB-1:0] ay;
    logic           vb;
    logic           fs;
  } early_t;

  logic           clk = 1'b0;
  logic           rst, pix_en, grid_en;
  logic [NXB-1:0] adr_x_vga;
  logic [NYB-1:0] adr_y_vga;
  logic [SB-1:0]  vga_state;
  logic           hsync, vsync, de, vblank, frame_start;
  logic [11:0]    rgb;

  logic [SB-1:0]  cells [NPX][NPY];
  out_t           exp_q[$];
  early_t         early_q[$];
  int             mh, mv;
  int             n_pass = 0, n_total = 0;
  logic           m_en;
  out_t           snap_out, e_out;
  logic [NXB+NYB:0] snap_adr;
  early_t         e_early;

  always #5 clk = ~clk;

  // pe_array read port stand-in: cell state follows the requested address
  assign vga_state = cells[adr_x_vga][adr_y_vga];

  vga_cell_scanner #(
    .H_ACTIVE(T_HA), .H_FP(T_HFP), .H_SYNC(T_HS), .H_BP(T_HBP),
    .V_ACTIVE(T_VA), .V_FP(T_VFP), .V_SYNC(T_VS), .V_BP(T_VBP),
    .CELL_SHIFT(T_CS), .RD_LAT(T_RDL)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .grid_en(grid_en),
    .adr_x_vga(adr_x_vga), .adr_y_vga(adr_y_vga), .vga_state(vga_state),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .vblank(vblank), .frame_start(frame_start)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic out_t ref_pixel(input int x, input int y, input logic gen);
    out_t r;
    int cx, cy;
    cx = x / CPX;
    cy = y / CPX;
    r.hs = !(x >= T_HA + T_HFP && x < T_HA + T_HFP + T_HS);
    r.vs = !(y >= T_VA + T_VFP && y < T_VA + T_VFP + T_VS);
    r.de = (x < T_HA) && (y < T_VA);
    if (!r.de)                                  r.rgb = 12'h000;
    else if (cx >= NPX || cy >= NPY)            r.rgb = 12'h00F;
    else if (gen && (x % CPX == 0 || y % CPX == 0)) r.rgb = 12'h444;
    else if (cells[cx][cy][0])                  r.rgb = 12'hFFF;
    else                                        r.rgb = 12'h000;
    return r;
  endfunction

  function automatic early_t ref_early(input int x, input int y);
    early_t e;
    int nx, ny;
    logic vis;
    vis  = (x < T_HA) && (y < T_VA) && (x / CPX < NPX) && (y / CPX < NPY);
    e.ax = vis ? NXB'(x / CPX) : '0;
    e.ay = vis ? NYB'(y / CPX) : '0;
    nx = x + 1;
    ny = y;
    if (nx == T_HT) begin
      nx = 0;
      ny = (y + 1 == T_VT) ? 0 : y + 1;
    end
    e.vb = (ny >= T_VA);
    e.fs = (nx == 0) && (ny == T_VA);
    return e;
  endfunction

  task automatic randomize_cells();
    for (int x = 0; x < NPX; x++)
      for (int y = 0; y < NPY; y++)
        cells[x][y] = SB'($urandom);
    cells[2][1] = SB'(1);
  endtask

  // One clk: optionally a pix_en step, with the expected response queued before the edge
  task automatic tick(input logic en);
    @(negedge clk);
    if (en && mv == T_VA + 1 && mh == 0) grid_en = ~grid_en;
    pix_en = en;
    if (en) begin
      exp_q.push_back(ref_pixel(mh, mv, grid_en));
      early_q.push_back(ref_early(mh, mv));
      mh++;
      if (mh == T_HT) begin
        mh = 0;
        mv = (mv + 1 == T_VT) ? 0 : mv + 1;
      end
    end
  endtask

  task automatic run_steps(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap));
      repeat (gap) tick(1'b0);
      tick(1'b1);
    end
  endtask

  task automatic run_to(input int x, input int y, input int max_gap);
    int budget;
    budget = 2 * FRAME;
    while (!(mh == x && mv == y) && budget > 0) begin
      run_steps(1, max_gap);
      budget--;
    end
    if (budget == 0) begin
      n_total++;
      $display("FAIL run_to timeout: at (%0d,%0d) wanted (%0d,%0d)", mh, mv, x, y);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, 64'(hsync), 64'd1);
    check({tag, "_vsync"}, 64'(vsync), 64'd1);
    check({tag, "_de"}, 64'(de), 64'd0);
    check({tag, "_rgb"}, 64'(rgb), 64'd0);
    check({tag, "_adr"}, 64'({adr_x_vga, adr_y_vga}), 64'd0);
    check({tag, "_vblank"}, 64'(vblank), 64'd0);
    check({tag, "_frame_start"}, 64'(frame_start), 64'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    mh = 0;
    mv = 0;
    exp_q.delete();
    early_q.delete();
    for (int i = 0; i < T_RDL; i++) begin
      exp_q.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 12'h000});
    end
    // The first pix_en step after reset shows reset-state address/vblank on the second queue
    for (int i = 0; i < T_RDL; i++) begin
      if (i > 0) early_q.push_back('0);
    end
  endtask

  // Monitor: every step pops one expected entry; idle clks must leave outputs frozen
  always @(posedge clk) begin
    m_en = pix_en;
    #1;
    if (rst) begin
      snap_out = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 12'h000};
      snap_adr = '0;
    end else if (m_en) begin
      if (exp_q.size() == 0 || early_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow at %0t: got %0d/%0d queued entries expected >0",
                 $time, exp_q.size(), early_q.size());
      end else begin
        e_out   = exp_q.pop_front();
        e_early = early_q.pop_front();
        check("pixel_out", 64'({hsync, vsync, de, rgb}), 64'(e_out));
        check("addr_vblank_fs", 64'({adr_x_vga, adr_y_vga, vblank, frame_start}), 64'(e_early));
      end
      snap_out = '{hs: hsync, vs: vsync, de: de, rgb: rgb};
      snap_adr = {adr_x_vga, adr_y_vga, vblank};
    end else begin
      check("frozen", 64'({hsync, vsync, de, rgb, adr_x_vga, adr_y_vga, vblank, frame_start}),
            64'({snap_out, snap_adr, 1'b0}));
    end
  end

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    grid_en = 1'b0;
    mh = 0;
    mv = 0;
    randomize_cells();
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    release_reset();

    run_steps(2 * FRAME, 4);

    run_to(20, 10, 4);
    repeat (50) tick(1'b0);
    run_steps(FRAME / 2, 4);

    run_steps(FRAME, 0);

    run_to(30, 20, 4);
    @(negedge clk);
    pix_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    randomize_cells();
    repeat (2) @(negedge clk);
    release_reset();
    run_steps(FRAME + 200, 4);
    repeat (4) tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
